// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - debounced single-step / burst / free-run CPU clock pulse controller
module cpu_step_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int RUN_DIV    = 25000000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        button,
    input  logic        run_sw,
    input  logic        burst_sw,
    input  logic [3:0]  burst_len,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] curPC,
    input  logic        clr_cnt,
    output logic        CLK_CPU,
    output logic        busy,
    output logic        halted,
    output logic [15:0] step_count
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_SAT  = DEB_W'(DEB_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_BURST,
        S_RUN,
        S_HALT
    } state_t;

    logic [1:0]       r_sync;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             w_button_s;
    logic             w_press;
    logic             w_bp_hit;

    state_t           r_state;
    logic [4:0]       r_remaining;
    logic [DIV_W-1:0] r_div;
    logic             r_gap;
    logic             r_first;
    logic             r_clk_cpu;
    logic             r_busy;
    logic             r_halted;
    logic [15:0]      r_step_count;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], button};
        end
    end

    assign w_button_s = r_sync[1];

    // Saturating at DEB_CYCLES keeps the strobe to one per hold.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_deb_cnt <= '0;
        end else if (!w_button_s) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt != DEB_SAT) begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    assign w_press  = w_button_s && (r_deb_cnt == DEB_LAST);
    assign w_bp_hit = bp_en && (curPC == bp_addr);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_div       <= '0;
            r_gap       <= 1'b0;
            r_first     <= 1'b0;
            r_clk_cpu   <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_clk_cpu <= 1'b0;
            r_busy    <= (r_state == S_BURST) || (r_state == S_RUN);
            r_halted  <= (r_state == S_HALT);
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        r_first <= 1'b1;
                        r_gap   <= 1'b0;
                        r_div   <= '0;
                        if (run_sw) begin
                            r_state <= S_RUN;
                        end else if (burst_sw) begin
                            r_state     <= S_BURST;
                            r_remaining <= (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
                        end else begin
                            r_state <= S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    r_clk_cpu <= 1'b1;
                    r_state   <= S_IDLE;
                end
                S_BURST: begin
                    if (r_gap) begin
                        r_gap <= 1'b0;
                    end else if (!r_first && w_bp_hit) begin
                        r_state <= S_HALT;
                    end else begin
                        r_clk_cpu   <= 1'b1;
                        r_first     <= 1'b0;
                        r_gap       <= 1'b1;
                        r_remaining <= r_remaining - 5'd1;
                        if (r_remaining == 5'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_RUN: begin
                    if (w_press || !run_sw) begin
                        r_state <= S_IDLE;
                    end else if (r_div != DIV_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!r_first && w_bp_hit) begin
                            r_state <= S_HALT;
                        end else begin
                            r_clk_cpu <= 1'b1;
                            r_first   <= 1'b0;
                        end
                    end
                end
                S_HALT: begin
                    if (w_press) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_step_count <= '0;
        end else if (clr_cnt) begin
            r_step_count <= '0;
        end else if (r_clk_cpu) begin
            r_step_count <= r_step_count + 16'd1;
        end
    end

    assign CLK_CPU    = r_clk_cpu;
    assign busy       = r_busy;
    assign halted     = r_halted;
    assign step_count = r_step_count;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - randomized and directed bench with behavioural pulse model
module tb_cpu_step_ctrl;
    localparam int DEB = 4;
    localparam int DIV = 8;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        button = 1'b0;
    logic        run_sw = 1'b0;
    logic        burst_sw = 1'b0;
    logic [3:0]  burst_len = 4'd0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] curPC = 32'd0;
    logic        clr_cnt = 1'b0;
    logic        CLK_CPU;
    logic        busy;
    logic        halted;
    logic [15:0] step_count;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;
    bit pc_auto = 1'b0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse = 0;
    int pulse_gap = 0;

    cpu_step_ctrl #(.DEB_CYCLES(DEB), .RUN_DIV(DIV)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .button     (button),
        .run_sw     (run_sw),
        .burst_sw   (burst_sw),
        .burst_len  (burst_len),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .curPC      (curPC),
        .clr_cnt    (clr_cnt),
        .CLK_CPU    (CLK_CPU),
        .busy       (busy),
        .halted     (halted),
        .step_count (step_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press_btn(input int hold, input int after);
        button = 1'b1;
        wait_cyc(hold);
        button = 1'b0;
        wait_cyc(after);
    endtask

    // Behavioural model: mode 0 idle, 1 step, 2 burst, 3 run, 4 halt;
    // m_wait counts edges until the next pulse decision.
    int          m_mode, m_left, m_wait, m_done, m_run;
    logic [1:0]  m_sync;
    logic        m_clk, m_busy, m_halted;
    logic [15:0] m_cnt;

    always @(posedge CLK or negedge Reset) begin : model
        bit bs, pr, pulse, bp;
        if (!Reset) begin
            m_mode = 0; m_left = 0; m_wait = 0; m_done = 0; m_run = 0;
            m_sync = 2'b00; m_clk = 1'b0; m_busy = 1'b0; m_halted = 1'b0; m_cnt = 16'd0;
        end else begin
            bs = m_sync[1];
            pr = bs && (m_run == DEB - 1);
            bp = bp_en && (curPC == bp_addr);
            pulse = 1'b0;
            m_busy = (m_mode == 2) || (m_mode == 3);
            m_halted = (m_mode == 4);
            if (clr_cnt) m_cnt = 16'd0;
            else if (m_clk) m_cnt = m_cnt + 16'd1;
            case (m_mode)
                0: if (pr) begin
                    m_done = 0;
                    if (run_sw) begin m_mode = 3; m_wait = DIV; end
                    else if (burst_sw) begin
                        m_mode = 2; m_wait = 1;
                        m_left = (burst_len == 0) ? 16 : int'(burst_len);
                    end else m_mode = 1;
                end
                1: begin pulse = 1'b1; m_mode = 0; end
                2: if (m_wait > 1) m_wait--;
                   else if (m_done > 0 && bp) m_mode = 4;
                   else begin
                       pulse = 1'b1; m_done++; m_left--; m_wait = 2;
                       if (m_left == 0) m_mode = 0;
                   end
                3: if (pr || !run_sw) m_mode = 0;
                   else if (m_wait > 1) m_wait--;
                   else begin
                       m_wait = DIV;
                       if (m_done > 0 && bp) m_mode = 4;
                       else begin pulse = 1'b1; m_done++; end
                   end
                4: if (pr) m_mode = 0;
                default: m_mode = 0;
            endcase
            m_clk = pulse;
            m_run = bs ? ((m_run < DEB) ? m_run + 1 : m_run) : 0;
            m_sync = {m_sync[0], button};
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("model_clk_cpu", CLK_CPU, m_clk);
            chk("model_busy", busy, m_busy);
            chk("model_halted", halted, m_halted);
            chk("model_step_count", step_count, m_cnt);
        end
        if (CLK_CPU) begin
            pulses++;
            pulse_gap = cyc - last_pulse;
            last_pulse = cyc;
            if (pc_auto) curPC = curPC + 32'd4;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        wait_cyc(3);
        chk("reset_clk_cpu", CLK_CPU, 0);
        chk("reset_busy", busy, 0);
        chk("reset_halted", halted, 0);
        chk("reset_step_count", step_count, 0);
        Reset = 1'b1;
        cmp_en = 1'b1;
        wait_cyc(2);

        pulses = 0;
        press_btn(10, 10);
        chk("step_pulses", pulses, 1);
        chk("step_count_one", step_count, 1);

        pulses = 0;
        press_btn(2, 10);
        chk("glitch_no_pulse", pulses, 0);

        burst_sw = 1'b1; burst_len = 4'd3; pulses = 0;
        press_btn(6, 4);
        chk("burst_busy_mid", busy, 1);
        wait_cyc(20);
        chk("burst3_pulses", pulses, 3);
        chk("burst3_spacing", pulse_gap, 2);
        chk("burst3_idle", busy, 0);

        burst_len = 4'd0; pulses = 0;
        press_btn(6, 40);
        chk("burst16_pulses", pulses, 16);

        burst_sw = 1'b0; run_sw = 1'b1; pulses = 0;
        press_btn(6, 40);
        chk("run_pulses_min", (pulses >= 4), 1);
        chk("run_spacing", pulse_gap, DIV);
        chk("run_busy", busy, 1);
        press_btn(6, 0);
        pulses = 0;
        wait_cyc(30);
        chk("run_stop_pulses", pulses, 0);
        chk("run_stop_busy", busy, 0);
        run_sw = 1'b0;

        burst_sw = 1'b1; burst_len = 4'd8; bp_en = 1'b1; bp_addr = 32'h0C;
        curPC = 32'd0; pc_auto = 1'b1; pulses = 0;
        press_btn(6, 30);
        chk("bp_pulses", pulses, 3);
        chk("bp_halted", halted, 1);
        pulses = 0;
        press_btn(6, 10);
        chk("bp_release_no_pulse", pulses, 0);
        chk("bp_release_halted", halted, 0);
        bp_en = 1'b0; pc_auto = 1'b0;

        burst_len = 4'd0;
        press_btn(6, 0);
        for (int i = 0; i < 20 && !CLK_CPU; i++) @(negedge CLK);
        chk("reset_pulse_seen", CLK_CPU, 1);
        #2 Reset = 1'b0;
        #1;
        chk("async_reset_clk_cpu", CLK_CPU, 0);
        chk("async_reset_step_count", step_count, 0);
        chk("async_reset_busy", busy, 0);
        @(negedge CLK);
        Reset = 1'b1;
        pulses = 0;
        wait_cyc(20);
        chk("post_reset_no_pulse", pulses, 0);
        chk("post_reset_idle", busy, 0);

        for (int it = 0; it < 80; it++) begin
            run_sw    = ($urandom_range(0, 3) == 0);
            burst_sw  = $urandom_range(0, 1);
            burst_len = 4'($urandom);
            bp_en     = $urandom_range(0, 1);
            bp_addr   = 32'(4 * $urandom_range(0, 6));
            if ($urandom_range(0, 2) == 0) curPC = 32'd0;
            pc_auto   = 1'b1;
            clr_cnt   = ($urandom_range(0, 9) == 0);
            press_btn($urandom_range(1, 8), $urandom_range(1, 12));
            clr_cnt = 1'b0;
            if ($urandom_range(0, 3) == 0) run_sw = 1'b0;
            wait_cyc($urandom_range(1, 30));
        end
        run_sw = 1'b0; burst_sw = 1'b0; bp_en = 1'b0; pc_auto = 1'b0;
        wait_cyc(40);
        if (m_mode == 4) press_btn(6, 10);

        clr_cnt = 1'b1;
        wait_cyc(1);
        clr_cnt = 1'b0;
        chk("clear_idle", step_count, 0);
        burst_sw = 1'b1; burst_len = 4'd0;
        repeat (4095) press_btn(5, 30);
        burst_len = 4'd15;
        press_btn(5, 40);
        chk("preload_ffff", step_count, 16'hFFFF);
        burst_sw = 1'b0;
        press_btn(6, 10);
        chk("wrap_to_zero", step_count, 0);

        button = 1'b1;
        for (int i = 0; i < 20 && !CLK_CPU; i++) @(negedge CLK);
        chk("clr_pulse_seen", CLK_CPU, 1);
        clr_cnt = 1'b1;
        @(negedge CLK);
        clr_cnt = 1'b0;
        button = 1'b0;
        chk("clr_beats_increment", step_count, 0);
        wait_cyc(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000: cycles `button_s` must stay high to register a press.
REQ-002 SHALL have parameter RUN_DIV, default 25000000: CLK cycles between pulses in RUN.
REQ-003 SHALL have port CLK  in  1  system clock; all logic on posedge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port button  in  1  raw push-button, asynchronous.
REQ-006 SHALL have port run_sw  in  1  level; 1 selects free-run mode.
REQ-007 SHALL have port burst_sw  in  1  level; 1 selects burst mode.
REQ-008 SHALL have port burst_len  in  4  pulses per burst; 0 means 16.
REQ-009 SHALL have port bp_en  in  1  breakpoint enable.
REQ-010 SHALL have port bp_addr  in  32  breakpoint PC.
REQ-011 SHALL have port curPC  in  32  CPU current PC.
REQ-012 SHALL have port clr_cnt  in  1  synchronous clear of step_count.
REQ-013 SHALL have port CLK_CPU  out  1  registered CPU clock pulse.
REQ-014 SHALL have port busy  out  1  high in BURST or RUN.
REQ-015 SHALL have port halted  out  1  high in HALT.
REQ-016 SHALL have port step_count  out  16  CLK_CPU pulses issued.

Function
REQ-017 SHALL synchronise button through 2 flops to button_s; raw button SHALL NOT reach any other logic.
REQ-018 SHALL count consecutive button_s-high cycles (saturating) and zero the count on button_s low; press SHALL be a 1-cycle strobe when count == DEB_CYCLES-1, exactly once per hold.
REQ-019 SHALL implement FSM states IDLE, STEP, BURST, RUN, HALT.
REQ-020 IDLE + press: run_sw=1 -> RUN; else burst_sw=1 -> BURST with remaining=burst_len (0->16); else -> STEP. run_sw SHALL have priority over burst_sw.
REQ-021 STEP SHALL drive CLK_CPU=1 for exactly one cycle, then return to IDLE.
REQ-022 BURST SHALL alternate pulse/gap cycles (pulse, low, pulse, ...) and decrement remaining per pulse; after the pulse taking remaining to 0 -> IDLE.
REQ-023 RUN SHALL count 0..RUN_DIV-1 and pulse on the terminal count; press or run_sw=0 -> IDLE with no further pulse.
REQ-024 In BURST/RUN, before every pulse except the first since entry, if bp_en && curPC==bp_addr the pulse SHALL be suppressed and FSM -> HALT.
REQ-025 HALT SHALL issue no pulses; press -> IDLE, consuming that press without a pulse.
REQ-026 CLK_CPU SHALL be registered and high at most one cycle, with at least one low cycle between any two pulses.
REQ-027 press SHALL be ignored in STEP and BURST.
REQ-028 step_count SHALL increment on each CLK_CPU pulse and wrap 16'hFFFF->0; clr_cnt SHALL win over a simultaneous increment.
REQ-029 busy and halted SHALL be registered decodes of the FSM state.

Reset
REQ-030 Reset=0 SHALL immediately force CLK_CPU=0, busy=0, halted=0, step_count=0, FSM=IDLE, sync flops, debounce count, remaining and divider to 0, including mid-pulse or mid-burst.
REQ-031 After Reset rises, no pulse SHALL issue until a new full debounce press.

Verification (DEB_CYCLES=4, RUN_DIV=8)
REQ-032 Step: button high 10 cycles, switches 0 -> exactly 1 CLK_CPU pulse; step_count=1; glitch of 2 cycles -> no pulse.
REQ-033 Burst: burst_sw=1, burst_len=3, press -> 3 pulses 2 cycles apart, busy high throughout, then IDLE; burst_len=0 -> 16 pulses.
REQ-034 Run: run_sw=1, press -> pulses every 8 cycles; second press -> pulses stop, busy=0.
REQ-035 Breakpoint: bp_en=1, bp_addr=0x0C, curPC advancing by 4 per pulse from 0x00, burst_len=8 -> 3 pulses, halted=1; press -> IDLE, no pulse.
REQ-036 Reset: Reset=0 asserted during a CLK_CPU high cycle in BURST -> CLK_CPU=0 that cycle, step_count=0, idle after release.
REQ-037 Wrap/clear: preload via 65535 steps -> next pulse yields 0; clr_cnt concurrent with a pulse -> 0.
